// File: rtl/branch_predictor_gshare.sv
// gshare predictor: zero-latency prediction from a PC^GHR-indexed counter table; never stalls, a full FIFO drops the push and sets o_overflow.
// Optional macro BP_FB_PC_CHECK_EN tags FIFO entries with PC bits and adds the sticky o_desync output.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_predictor_gshare #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int INDEX_BITS = 8,
  parameter int GHR_BITS   = 6,
  parameter int CTR_BITS   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  input  logic [ADDR_WIDTH-1:0] i_req_target,
  output logic                  o_req_prediction,  // 1 = TAKEN, 0 = NOT_TAKEN
  input  logic                  i_fb_valid,
  input  logic [ADDR_WIDTH-1:0] i_fb_pc,
  input  logic                  i_fb_prediction,
  input  logic                  i_fb_outcome,
  output logic                  o_overflow,
  output logic                  o_underflow
`ifdef BP_FB_PC_CHECK_EN
  ,
  output logic                  o_desync
`endif
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CW       = PTR_BITS + 1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN  = '0;
  localparam logic [CW-1:0]       DEPTH    = CW'(FIFO_DEPTH);

  logic [CTR_BITS-1:0]   ctr [ENTRIES];
  logic [GHR_BITS-1:0]   ghr;
  logic [INDEX_BITS-1:0] fifo_idx [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]         count;

  logic [INDEX_BITS-1:0] req_idx, fb_idx, train_idx;
  logic fifo_empty, fifo_full, mispredict, pop, push, flush, train, desync;

  assign req_idx          = i_req_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
  assign fb_idx           = i_fb_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
  assign o_req_prediction = ctr[req_idx][CTR_BITS-1];

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH);
  assign mispredict = i_fb_valid && (i_fb_prediction != i_fb_outcome);
  assign pop        = i_fb_valid && !fifo_empty;
  assign train_idx  = fifo_empty ? fb_idx : fifo_idx[rd_ptr];

`ifdef BP_FB_PC_CHECK_EN
  logic [INDEX_BITS-1:0] fifo_pc [FIFO_DEPTH];
  assign desync = pop && (fifo_pc[rd_ptr] != i_fb_pc[INDEX_BITS+1:2]);

  always_ff @(posedge clk) begin
    if (push) fifo_pc[wr_ptr] <= i_req_pc[INDEX_BITS+1:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      o_desync <= 1'b0;
    else if (desync) o_desync <= 1'b1;
  end
`else
  assign desync = 1'b0;
`endif

  // A flush squashes every younger branch, including one requesting this cycle.
  assign flush = mispredict || desync;
  assign train = i_fb_valid && !desync;
  assign push  = i_req_valid && !flush && (!fifo_full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
    end else if (train) begin
      if (i_fb_outcome && (ctr[train_idx] != CTR_MAX))
        ctr[train_idx] <= ctr[train_idx] + CTR_BITS'(1);
      else if (!i_fb_outcome && (ctr[train_idx] != CTR_MIN))
        ctr[train_idx] <= ctr[train_idx] - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ghr <= '0;
    else if (i_fb_valid) ghr <= (ghr << 1) | GHR_BITS'(i_fb_outcome);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_idx[wr_ptr] <= req_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_req_valid && fifo_full && !pop) o_overflow  <= 1'b1;
      if (i_fb_valid && fifo_empty)         o_underflow <= 1'b1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{i_req_target, i_req_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_req_pc[1:0],
                         i_fb_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_fb_pc[1:0]};

endmodule
